core_ctrl: RTL

Kernel sequencer for the GEMM core. It sits between the input batch controller and the output controller. Once the source buffer is full (`s_init`), it runs the multiply-accumulate loop over four output groups, issuing source and parameter read addresses for each. It then pulses `k_fin` to hand each group to the output controller, and pulses `s_fin` when the whole batch is finished so the destination stream can start.

---
 rtl/gemm_pkg.sv | 29 ++
 rtl/core_ctrl_if.sv | 38 +++
 rtl/core_ctrl_loop1.sv | 47 ++++
 rtl/core_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gemm_pkg                                                      |
// | Purpose  : Shared types and constants for the GEMM core sequencer.       |
// |            Holds the kernel FSM state enum, the read-address widths and  |
// |            the default loop dimensions.                                  |
// | Contents : core_state_e, SRC_AW, PRM_AW, K_N_DEF, OG_N_DEF, LAT_DEF      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package gemm_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      INIT  = 3'd2,
      EXEC  = 3'd3,
      DRAIN = 3'd4,
      FIN   = 3'd5
   } core_state_e;

   localparam int SRC_AW   = 5;
   localparam int PRM_AW   = 3;

   localparam int K_N_DEF  = 8;
   localparam int OG_N_DEF = 4;
   localparam int LAT_DEF  = 2;

endpackage
`default_nettype wire

// File: rtl/core_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : core_ctrl_if                                                  |
// | Purpose  : Handshake and read-address bundle between the kernel         |
// |            sequencer and its neighbours (batch controller, MAC array,    |
// |            output controller).                                           |
// | Ports    : master = sequencer side (drives k_init/exec/src_ra/prm_ra/    |
// |            k_fin/s_fin/busy/ovr, samples run/s_init/out_busy);           |
// |            slave  = environment side (the mirror image).                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface core_ctrl_if;
   import gemm_pkg::*;

   logic              run;
   logic              s_init;
   logic              out_busy;
   logic              k_init;
   logic              exec;
   logic [SRC_AW-1:0] src_ra;
   logic [PRM_AW-1:0] prm_ra;
   logic              k_fin;
   logic              s_fin;
   logic              busy;
   logic              ovr;

   modport master (
      input  run, s_init, out_busy,
      output k_init, exec, src_ra, prm_ra, k_fin, s_fin, busy, ovr
   );

   modport slave (
      output run, s_init, out_busy,
      input  k_init, exec, src_ra, prm_ra, k_fin, s_fin, busy, ovr
   );

endinterface
`default_nettype wire

// File: rtl/core_ctrl_loop1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : loop1                                                         |
// | Purpose  : Single loop-index counter. Loads INI on clr_i, advances by    |
// |            one on en_i and wraps back to INI after reaching FIN.         |
// | Ports    : clk, reset (async, active-high), clr_i, en_i,                 |
// |            cnt_o (current index), fin_o (index equals FIN)               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module loop1 #(
   parameter int W   = 3,
   parameter int INI = 0,
   parameter int FIN = 7
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         fin_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign fin_o = (cnt_q == W'(FIN));
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = W'(INI);
      end else if (en_i) begin
         cnt_d = fin_o ? W'(INI) : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= W'(INI);
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : core_ctrl                                                     |
// | Purpose  : Kernel sequencer for the GEMM core. After the source buffer   |
// |            fills (s_init) it runs the MAC loop for each output group,    |
// |            issuing source/parameter read addresses, hands each group to  |
// |            the output controller with k_fin and flags batch completion   |
// |            with s_fin once the output side is idle.                      |
// | Ports    : clk, reset (async, active-high), bus (core_ctrl_if.master)    |
// | Config   : CORE_CTRL_OVR_DETECT_EN - when defined, ovr latches an        |
// |            s_init that arrives mid-batch; otherwise ovr is tied low.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module core_ctrl
   import gemm_pkg::*;
#(
   parameter int K_N  = K_N_DEF,
   parameter int OG_N = OG_N_DEF,
   parameter int LAT  = LAT_DEF
)(
   input  logic        clk,
   input  logic        reset,
   core_ctrl_if.master bus
);

   localparam int KW = (K_N  > 1) ? $clog2(K_N)  : 1;
   localparam int OW = (OG_N > 1) ? $clog2(OG_N) : 1;
   localparam int DW = (LAT  > 1) ? $clog2(LAT)  : 1;

   generate
      if ((OG_N * K_N > (1 << SRC_AW)) || (K_N < 2) || (OG_N < 2) || (LAT < 1)) begin : g_cfg_err
         $error("core_ctrl: unsupported K_N/OG_N/LAT combination");
      end
   endgenerate

   core_state_e   state_q, state_d;
   logic          last_q,  last_d;
   logic [DW-1:0] dc_q,    dc_d;
   logic          s_fin_q, s_fin_d;

   logic          k_clr, k_en, k_last;
   logic          og_clr, og_en, og_last;
   logic [KW-1:0] k_q;
   logic [OW-1:0] og_q;

   loop1 #(.W(KW), .INI(0), .FIN(K_N - 1)) u_k_loop (
      .clk   (clk),
      .reset (reset),
      .clr_i (k_clr),
      .en_i  (k_en),
      .cnt_o (k_q),
      .fin_o (k_last)
   );

   loop1 #(.W(OW), .INI(0), .FIN(OG_N - 1)) u_og_loop (
      .clk   (clk),
      .reset (reset),
      .clr_i (og_clr),
      .en_i  (og_en),
      .cnt_o (og_q),
      .fin_o (og_last)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      dc_d    = dc_q;
      s_fin_d = 1'b0;
      k_clr   = 1'b0;
      k_en    = 1'b0;
      og_clr  = 1'b0;
      og_en   = 1'b0;

      if (!bus.run) begin
         // Abort beats everything, including an s_init in the same cycle.
         state_d = IDLE;
         last_d  = 1'b0;
         dc_d    = '0;
         k_clr   = 1'b1;
         og_clr  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.s_init) begin
                  state_d = WAIT;
                  last_d  = 1'b0;
                  og_clr  = 1'b1;
               end
            end
            WAIT: begin
               // Holding here until the output side is idle keeps k_init
               // from clearing accumulators that are still being drained.
               if (!bus.out_busy) begin
                  if (last_q) begin
                     state_d = IDLE;
                     last_d  = 1'b0;
                     s_fin_d = 1'b1;
                  end else begin
                     state_d = INIT;
                  end
               end
            end
            INIT: begin
               state_d = EXEC;
               k_clr   = 1'b1;
            end
            EXEC: begin
               k_en = 1'b1;
               if (k_last) begin
                  state_d = DRAIN;
                  dc_d    = DW'(LAT - 1);
               end
            end
            DRAIN: begin
               if (dc_q == '0) begin
                  state_d = FIN;
               end else begin
                  dc_d = dc_q - DW'(1);
               end
            end
            FIN: begin
               state_d = WAIT;
               if (og_last) begin
                  last_d = 1'b1;
               end else begin
                  og_en = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         dc_q    <= '0;
         s_fin_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         dc_q    <= dc_d;
         s_fin_q <= s_fin_d;
      end
   end

   // Outputs are decoded from registered state and counters only.
   always_comb begin
      bus.k_init = (state_q == INIT);
      bus.exec   = (state_q == EXEC);
      bus.k_fin  = (state_q == FIN);
      bus.busy   = (state_q != IDLE);
      bus.s_fin  = s_fin_q;
      bus.src_ra = '0;
      bus.prm_ra = '0;
      if (state_q == EXEC) begin
         bus.src_ra = SRC_AW'(int'(og_q) * K_N + int'(k_q));
         bus.prm_ra = PRM_AW'(k_q);
      end
   end

`ifdef CORE_CTRL_OVR_DETECT_EN
   logic ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (!bus.run) begin
         ovr_d = 1'b0;
      end else if (bus.s_init && (state_q != IDLE)) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr_q <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign bus.ovr = ovr_q;
`else
   assign bus.ovr = 1'b0;
`endif

endmodule
`default_nettype wire
